// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES    = 4;
  localparam int unsigned IMEM_BYTES_DEF = 128;
  localparam int unsigned MEM_AW_DEF     = 7;
  localparam int unsigned ADDR_W_DEF     = 32;

endpackage

// File: rtl/instr_byte_packer.sv
// Collects four bytes MSB-first into a 32-bit instruction word.
module instr_byte_packer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  output logic [31:0] word_c,
  output logic        done_c
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  // The fourth byte bypasses the register so the word is usable in the same cycle.
  assign word_c = {sr, data_in};
  assign done_c = shift_en && !clear && (cnt == 2'(INSTR_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[15:0], data_in};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Self-sequencing fetch stage: owns the PC, reads byte-wide IMEM and hands
// big-endian instruction words downstream over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned MEM_AW     = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - INSTR_BYTES);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] redir_pc;
  logic [1:0]        k;
  logic              rd_valid;
  logic              launch;
  logic              tgt_fits;
  logic [31:0]       pk_word;
  logic              pk_done;

  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign tgt_fits = (tgt <= LAST_PC);

  // Next PC and whether a new fetch (or halt) is launched this cycle.
  always_comb begin
    launch = 1'b0;
    tgt    = pc;
    case (state)
      IDLE: begin
        if (redirect_valid) tgt = redir_pc;
        else if (start)     launch = 1'b1;
      end
      FETCH: begin
        if (redirect_valid) begin
          tgt    = redir_pc;
          launch = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          tgt    = redir_pc;
          launch = 1'b1;
        end else if (instr_ready) begin
          tgt    = pc + ADDR_W'(INSTR_BYTES);
          launch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  instr_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .shift_en (rd_valid),
    .data_in  (mem_rd_data),
    .word_c   (pk_word),
    .done_c   (pk_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      k           <= '0;
      rd_valid    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc       <= tgt;
      // A launch orphans any byte still in flight from the old request stream.
      rd_valid <= mem_rd_en && !launch;
      if (launch) begin
        instr_valid <= 1'b0;
        k           <= '0;
        if (tgt_fits) begin
          state     <= FETCH;
          mem_rd_en <= 1'b1;
          mem_addr  <= tgt[MEM_AW-1:0];
          busy      <= 1'b1;
        end else begin
          state     <= DONE;
          mem_rd_en <= 1'b0;
          busy      <= 1'b0;
          halted    <= 1'b1;
        end
      end else if (state == FETCH) begin
        if (k != 2'd3) begin
          k        <= k + 2'd1;
          mem_addr <= mem_addr + MEM_AW'(1);
        end else begin
          mem_rd_en <= 1'b0;
        end
        if (pk_done) begin
          state       <= VALID;
          instr       <= pk_word;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a word-stream model feeds an expected
// queue, a negedge monitor pops and compares on every accepted handshake.
module tb_instr_fetch_unit;

  localparam int unsigned NB = 128;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_rd_en;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        halted;

  logic [7:0]  imem [NB];
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_halt;
  int          hs_pc8 = 0;
  int          hs_total = 0;
  logic [31:0] last_hs_pc = '0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_w;
  logic [31:0] held_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .halted         (halted)
  );

  // Synchronous IMEM: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? imem[mem_addr] : 8'($urandom);

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [6:0] b;
    b = a[6:0];
    return {imem[b], imem[b + 7'd1], imem[b + 7'd2], imem[b + 7'd3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: the stream of words the consumer should receive.
  task automatic m_advance();
    if (m_pc <= 32'(NB - 4)) exp_q.push_back({word_at(m_pc), m_pc});
    else begin
      m_halt = 1'b1;
      m_run  = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pc   = '0;
      m_run  = 1'b0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc & ~32'd3;
        if (m_run) m_advance();
      end else if (!m_run && start) begin
        m_run = 1'b1;
        m_advance();
      end else if (m_run && instr_valid && instr_ready) begin
        m_pc = m_pc + 32'd4;
        m_advance();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (stall_prev) begin
        check("hold_instr", instr, held_w);
        check("hold_pc", instr_pc, held_pc);
      end
      if (instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got pc %h, expected no word", instr_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_instr", instr, e.w);
          check("sb_pc", instr_pc, e.pc);
        end
        hs_total++;
        last_hs_pc = instr_pc;
        if (instr_pc == 32'd8) hs_pc8++;
      end
      stall_prev = !instr_ready && !redirect_valid;
      held_w     = instr;
      held_pc    = instr_pc;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_rd(input string name, input logic [6:0] a);
    int n;
    n = 0;
    while (!(mem_rd_en && mem_addr == a) && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(mem_rd_en && mem_addr == a), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(NB); i++) imem[i] = 8'($urandom);
    imem[0] = 8'h00; imem[1] = 8'h22; imem[2] = 8'h48; imem[3] = 8'h20;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    tick();

    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    rst = 1'b0;
    tick();

    // First word and its latency, then the following word.
    instr_ready = 1'b1;
    pulse_start();
    n = 1;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd6);
    check("t1_instr", instr, 32'h00224820);
    check("t1_pc", instr_pc, 32'd0);
    tick();
    wait_valid("t1_second_valid");
    check("t1_pc2", instr_pc, 32'd4);

    // Backpressure holds the word with no memory traffic.
    instr_ready = 1'b0;
    do_reset();
    pulse_start();
    wait_valid("t2_valid");
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2_hold_instr", instr, 32'h00224820);
      check("t2_hold_pc", instr_pc, 32'd0);
      check("t2_rd_en", 32'(mem_rd_en), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("t2_drop", 32'(instr_valid), 32'd0);
    wait_valid("t2_next_valid");
    check("t2_pc4", instr_pc, 32'd4);

    // Redirect mid-fetch restarts at the aligned target.
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    wait_rd("t3_k2", 7'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0013;
    tick();
    redirect_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("t3_rd_en", 32'(mem_rd_en), 32'd1);
      check("t3_addr", 32'(mem_addr), 32'(32'h10 + j));
      tick();
    end
    wait_valid("t3_valid");
    check("t3_pc", instr_pc, 32'h10);

    // Redirect coincident with the handshake at pc 8.
    instr_ready = 1'b0;
    do_reset();
    hs_pc8 = 0;
    pulse_start();
    for (int s = 0; s < 2; s++) begin
      wait_valid("t4_step_valid");
      check("t4_step_pc", instr_pc, 32'(4 * s));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
    wait_valid("t4_pc8_valid");
    check("t4_pc8", instr_pc, 32'd8);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("t4_drop", 32'(instr_valid), 32'd0);
    wait_valid("t4_tgt_valid");
    check("t4_tgt_pc", instr_pc, 32'h40);
    check("t4_pc8_once", 32'(hs_pc8), 32'd1);

    // Run to the end of IMEM, then DONE ignores start and redirect.
    hs_total    = 0;
    instr_ready = 1'b1;
    n = 0;
    while (!halted && n < 400) begin
      tick();
      n++;
    end
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_last_pc", last_hs_pc, 32'd124);
    check("t5_words", 32'(hs_total), 32'd16);
    pulse_start();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("t5_still_halted", 32'(halted), 32'd1);
    check("t5_still_idle_busy", 32'(busy), 32'd0);
    check("t5_no_rd", 32'(mem_rd_en), 32'd0);
    check("t5_no_valid", 32'(instr_valid), 32'd0);

    // Asynchronous reset mid-fetch and mid-handshake.
    instr_ready = 1'b0;
    do_reset();
    pulse_start();
    wait_rd("t6_k1", 7'd1);
    rst = 1'b1;
    #1;
    check("t6_fetch_rd_en", 32'(mem_rd_en), 32'd0);
    check("t6_fetch_addr", 32'(mem_addr), 32'd0);
    check("t6_fetch_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    pulse_start();
    wait_valid("t6_valid");
    rst = 1'b1;
    #1;
    check("t6_valid_drop", 32'(instr_valid), 32'd0);
    check("t6_valid_pc", instr_pc, 32'd0);
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    pulse_start();
    check("t6_restart_rd", 32'(mem_rd_en), 32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'd0);
    wait_valid("t6_restart_valid");
    check("t6_restart_pc", instr_pc, 32'd0);
    check("t6_restart_instr", instr, 32'h00224820);

    // Randomized traffic, all checked by the scoreboard.
    for (int c = 0; c < 2500; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'($urandom_range(0, 135));
      start          = ($urandom_range(0, 3) == 0);
      rst            = (halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
